// File: rtl/execute_stage_if.sv
// execute_stage_if: ID/EX inputs, writeback forwarding bus, redirect and EX/MEM outputs
// master: decode/hazard/writeback side (drives E-stage and W bus, receives redirect and M fields)
// slave:  execute_stage side
interface execute_stage_if #(parameter int XLEN = 32);
  logic            RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JALRctrlE, killE;
  logic [1:0]      SrcASelE, SrcBSelE;
  logic [3:0]      ALUopE;
  logic [2:0]      strCtrlE;
  logic [XLEN-1:0] immE, PCE, r1E, r2E;
  logic [4:0]      rs1E, rs2E, rdE;
  logic            RegWriteW;
  logic [4:0]      rdW;
  logic [XLEN-1:0] resultW;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM, MemWriteM, MemtoRegM;
  logic [2:0]      strCtrlM;
  logic [XLEN-1:0] ALUResultM, WriteDataM;
  logic [4:0]      rdM;
  modport master (
    output RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JALRctrlE, killE, SrcASelE, SrcBSelE,
           ALUopE, strCtrlE, immE, PCE, r1E, r2E, rs1E, rs2E, rdE, RegWriteW, rdW, resultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, MemtoRegM, strCtrlM, ALUResultM, WriteDataM, rdM
  );
  modport slave (
    input  RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JALRctrlE, killE, SrcASelE, SrcBSelE,
           ALUopE, strCtrlE, immE, PCE, r1E, r2E, rs1E, rs2E, rdE, RegWriteW, rdW, resultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, MemtoRegM, strCtrlM, ALUResultM, WriteDataM, rdM
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: RV32I execute stage - forwarding, ALU, branch/jump redirect, EX/MEM register
// Ports: clk, rst (async active-high), ex_if (execute_stage_if.slave).
// Redirect (PCSrcE/PCTargetE) is combinational; M fields are registered.
// Macro FWD_EN: when defined, MEM/WB forwarding is present; otherwise operands come straight from r1E/r2E.
module execute_stage #(parameter int XLEN = 32) (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave ex_if
);
  logic [XLEN-1:0] fa, fb, src_a, src_b, alu_y;
  logic            eq, lt, ltu, cond;
  logic            reg_write_q, mem_write_q, mem_to_reg_q;
  logic            reg_write_d, mem_write_d;
  logic [2:0]      str_ctrl_q;
  logic [XLEN-1:0] alu_result_q, write_data_q;
  logic [4:0]      rd_q, rd_d;
`ifdef FWD_EN
  // MEM beats WB; x0 never forwards
  assign fa = (reg_write_q && rd_q != 5'd0 && rd_q == ex_if.rs1E) ? alu_result_q :
              (ex_if.RegWriteW && ex_if.rdW != 5'd0 && ex_if.rdW == ex_if.rs1E) ? ex_if.resultW : ex_if.r1E;
  assign fb = (reg_write_q && rd_q != 5'd0 && rd_q == ex_if.rs2E) ? alu_result_q :
              (ex_if.RegWriteW && ex_if.rdW != 5'd0 && ex_if.rdW == ex_if.rs2E) ? ex_if.resultW : ex_if.r2E;
`else
  assign fa = ex_if.r1E;
  assign fb = ex_if.r2E;
`endif
  assign src_a = ex_if.SrcASelE == 2'b00 ? fa : ex_if.SrcASelE == 2'b01 ? ex_if.PCE : '0;
  assign src_b = ex_if.SrcBSelE == 2'b00 ? fb : ex_if.SrcBSelE == 2'b01 ? ex_if.immE :
                 ex_if.SrcBSelE == 2'b10 ? XLEN'(4) : '0;
  always_comb begin
    alu_y = src_a + src_b;
    case (ex_if.ALUopE)
      4'b0001: alu_y = src_a - src_b;
      4'b0010: alu_y = src_a << src_b[4:0];
      4'b0011: alu_y = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b0100: alu_y = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'b0101: alu_y = src_a ^ src_b;
      4'b0110: alu_y = src_a >> src_b[4:0];
      4'b0111: alu_y = $unsigned($signed(src_a) >>> src_b[4:0]);
      4'b1000: alu_y = src_a | src_b;
      4'b1001: alu_y = src_a & src_b;
      4'b1010: alu_y = src_b;
      default: ;
    endcase
  end
  assign eq  = fa == fb;
  assign lt  = $signed(fa) < $signed(fb);
  assign ltu = fa < fb;
  // funct3[0] inverts the base test; 01x encodes always (010) / never (011)
  assign cond = ex_if.strCtrlE[2:1] == 2'b00 ? eq ^ ex_if.strCtrlE[0] :
                ex_if.strCtrlE[2:1] == 2'b10 ? lt ^ ex_if.strCtrlE[0] :
                ex_if.strCtrlE[2:1] == 2'b11 ? ltu ^ ex_if.strCtrlE[0] : ~ex_if.strCtrlE[0];
  assign ex_if.PCSrcE    = ex_if.PCBranchE & cond & ~ex_if.killE;
  assign ex_if.PCTargetE = ex_if.JALRctrlE ? (fa + ex_if.immE) & ~XLEN'(1) : ex_if.PCE + ex_if.immE;
  assign reg_write_d = ex_if.RegWriteE & ~ex_if.killE;
  assign mem_write_d = ex_if.MemWriteE & ~ex_if.killE;
  assign rd_d        = ex_if.killE ? 5'd0 : ex_if.rdE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      str_ctrl_q   <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= ex_if.MemtoRegE;
      str_ctrl_q   <= ex_if.strCtrlE;
      alu_result_q <= alu_y;
      write_data_q <= fb;
      rd_q         <= rd_d;
    end
  end
  assign ex_if.RegWriteM  = reg_write_q;
  assign ex_if.MemWriteM  = mem_write_q;
  assign ex_if.MemtoRegM  = mem_to_reg_q;
  assign ex_if.strCtrlM   = str_ctrl_q;
  assign ex_if.ALUResultM = alu_result_q;
  assign ex_if.WriteDataM = write_data_q;
  assign ex_if.rdM        = rd_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage
module tb_execute_stage;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  execute_stage_if bus ();
  execute_stage dut (.clk(clk), .rst(rst), .ex_if(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RegWriteE = 0; bus.MemWriteE = 0; bus.MemtoRegE = 0; bus.PCBranchE = 0;
    bus.JALRctrlE = 0; bus.killE = 0; bus.SrcASelE = 0; bus.SrcBSelE = 0;
    bus.ALUopE = 0; bus.strCtrlE = 0; bus.immE = 0; bus.PCE = 0; bus.r1E = 0; bus.r2E = 0;
    bus.rs1E = 0; bus.rs2E = 0; bus.rdE = 0; bus.RegWriteW = 0; bus.rdW = 0; bus.resultW = 0;
  endtask

  typedef struct { logic [3:0] op; logic [31:0] a, b, y; } alu_vec_t;
  alu_vec_t alu_tab [12] = '{
    '{4'd0,  32'hFFFFFFFF, 32'h1,        32'h0},
    '{4'd1,  32'h0,        32'h1,        32'hFFFFFFFF},
    '{4'd2,  32'h1,        32'h21,       32'h2},
    '{4'd3,  32'hFFFFFFFF, 32'h1,        32'h1},
    '{4'd4,  32'hFFFFFFFF, 32'h1,        32'h0},
    '{4'd5,  32'hF0F0,     32'hFF00,     32'h0FF0},
    '{4'd6,  32'h80000000, 32'h4,        32'h08000000},
    '{4'd7,  32'h80000000, 32'h4,        32'hF8000000},
    '{4'd8,  32'hF0,       32'h0F,       32'hFF},
    '{4'd9,  32'hF0,       32'h3C,       32'h30},
    '{4'd10, 32'h123,      32'hABCDE000, 32'hABCDE000},
    '{4'd15, 32'h2,        32'h3,        32'h5}
  };

  initial begin
    idle();
    #2 rst = 1;
    #1;
    chk("rst_ALUResultM", bus.ALUResultM, 0);
    chk("rst_RegWriteM", bus.RegWriteM, 0);
    chk("rst_PCSrcE", bus.PCSrcE, 0);
    tick();
    rst = 0;
    // ADD x5 = 3 + 4
    bus.RegWriteE = 1; bus.rdE = 5; bus.r1E = 3; bus.SrcBSelE = 2'b01; bus.immE = 4;
    tick();
    chk("add_ALUResultM", bus.ALUResultM, 7);
    chk("add_rdM", bus.rdM, 5);
    chk("add_RegWriteM", bus.RegWriteM, 1);
    // dependent SUB: x8 = x5 - 3, stale r1E = 0
    idle();
    bus.RegWriteE = 1; bus.rdE = 8; bus.rs1E = 5; bus.r1E = 0; bus.rs2E = 7; bus.r2E = 3;
    bus.immE = 2; bus.ALUopE = 4'b0001;
    tick();
    chk("sub_fwd_ALUResultM", bus.ALUResultM, FWD ? 32'd4 : 32'hFFFFFFFD);
    // async reset mid-cycle
    #2 rst = 1;
    #1;
    chk("midrst_ALUResultM", bus.ALUResultM, 0);
    chk("midrst_RegWriteM", bus.RegWriteM, 0);
    chk("midrst_rdM", bus.rdM, 0);
    #1 rst = 0;
    // put x6 = 11 in M
    idle();
    bus.RegWriteE = 1; bus.rdE = 6; bus.r1E = 11; bus.SrcBSelE = 2'b11;
    tick();
    // MEM (11) vs WB (9) for rs1E = 6, observed via JALR target (fa+1)&~1
    idle();
    bus.RegWriteW = 1; bus.rdW = 6; bus.resultW = 9;
    bus.rs1E = 6; bus.r1E = 100; bus.SrcBSelE = 2'b11; bus.rdE = 6;
    bus.JALRctrlE = 1; bus.immE = 1;
    #1;
    chk("prio_mem_target", bus.PCTargetE, FWD ? 32'd12 : 32'd100);
    tick();
    chk("prio_mem_alu", bus.ALUResultM, FWD ? 32'd11 : 32'd100);
    chk("m_cleared_RegWriteM", bus.RegWriteM, 0);
    chk("wb_fwd_target", bus.PCTargetE, FWD ? 32'd10 : 32'd100);
    bus.rs1E = 0;
    #1;
    chk("rs0_target", bus.PCTargetE, 32'd100);
    bus.rdW = 0;
    #1;
    chk("rdw0_target", bus.PCTargetE, 32'd100);
    // branches, no forwarding sources active
    idle();
    bus.PCBranchE = 1; bus.r1E = 32'hFFFFFFFF; bus.r2E = 1; bus.PCE = 32'h100; bus.immE = 32'h20;
    bus.strCtrlE = 3'b100;
    #1;
    chk("blt_PCSrcE", bus.PCSrcE, 1);
    chk("blt_PCTargetE", bus.PCTargetE, 32'h120);
    bus.strCtrlE = 3'b110;
    #1;
    chk("bltu_PCSrcE", bus.PCSrcE, 0);
    bus.strCtrlE = 3'b101;
    #1;
    chk("bge_PCSrcE", bus.PCSrcE, 0);
    bus.strCtrlE = 3'b111;
    #1;
    chk("bgeu_PCSrcE", bus.PCSrcE, 1);
    bus.strCtrlE = 3'b011;
    #1;
    chk("never_PCSrcE", bus.PCSrcE, 0);
    bus.strCtrlE = 3'b001;
    #1;
    chk("bne_PCSrcE", bus.PCSrcE, 1);
    bus.PCBranchE = 0;
    #1;
    chk("nobranch_PCSrcE", bus.PCSrcE, 0);
    // JALR x1, 4(x?) with fa = 0x1003
    idle();
    bus.r1E = 32'h1003; bus.immE = 4; bus.JALRctrlE = 1; bus.PCBranchE = 1; bus.strCtrlE = 3'b010;
    bus.SrcASelE = 2'b01; bus.SrcBSelE = 2'b10; bus.PCE = 32'h40; bus.RegWriteE = 1; bus.rdE = 1;
    #1;
    chk("jalr_PCSrcE", bus.PCSrcE, 1);
    chk("jalr_PCTargetE", bus.PCTargetE, 32'h1006);
    tick();
    chk("jalr_link", bus.ALUResultM, 32'h44);
    chk("jalr_rdM", bus.rdM, 1);
    // killed taken BEQ carrying store/write controls
    idle();
    bus.PCBranchE = 1; bus.strCtrlE = 3'b000; bus.r1E = 5; bus.r2E = 5;
    bus.MemWriteE = 1; bus.RegWriteE = 1; bus.rdE = 3; bus.killE = 1;
    #1;
    chk("kill_PCSrcE", bus.PCSrcE, 0);
    tick();
    chk("kill_MemWriteM", bus.MemWriteM, 0);
    chk("kill_RegWriteM", bus.RegWriteM, 0);
    chk("kill_rdM", bus.rdM, 0);
    bus.killE = 0;
    #1;
    chk("beq_PCSrcE", bus.PCSrcE, 1);
    chk("beq_PCTargetE", bus.PCTargetE, 32'h0);
    tick();
    chk("store_MemWriteM", bus.MemWriteM, 1);
    chk("store_WriteDataM", bus.WriteDataM, 5);
    chk("store_strCtrlM", bus.strCtrlM, 0);
    // ALU operation table: A from r1E, B from immE
    for (int i = 0; i < 12; i++) begin
      idle();
      bus.ALUopE = alu_tab[i].op; bus.r1E = alu_tab[i].a; bus.SrcBSelE = 2'b01; bus.immE = alu_tab[i].b;
      bus.MemtoRegE = 1; bus.strCtrlE = 3'b101;
      tick();
      chk($sformatf("alu_op%0d", alu_tab[i].op), bus.ALUResultM, alu_tab[i].y);
    end
    chk("memtoreg_M", bus.MemtoRegM, 1);
    chk("strctrl_M", bus.strCtrlM, 3'b101);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
